game_controller: RTL and testbench
==================================

// Module: game_controller
// PURPOSE
//  Match-level controller placed directly downstream of the ball/paddle state machine.
//  Consumes its miss1/miss2 outputs and keeps scores and a BCD countdown clock.
//  Drives back its stop (serve/hold) and min (tens digit of seconds left, used for ball speed-up) inputs.
//  Sequences IDLE -> SERVE -> PLAY -> ... -> OVER and reports the winner to the display logic.
// PARAMETERS
//  CLK_PER_SEC   25_000_000  clk cycles per game second (25 MHz pixel clock)
//  SERVE_CYCLES  25_000_000  cycles stop is held before each serve
//  TIME_TENS     6           initial tens digit of match time, BCD 0..9
//  TIME_ONES     0           initial ones digit of match time, BCD 0..9
//  WIN_SCORE     9           score that ends the match immediately, 1..9
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous reset, active-high
//  start      in   1  one-cycle start/restart request
//  miss1      in   1  player1 missed (level, from ball state machine)
//  miss2      in   1  player2 missed (level, from ball state machine)
//  stop       out  1  hold ball/paddles at centre (registered)
//  min        out  4  BCD tens digit of seconds remaining
//  sec        out  4  BCD ones digit of seconds remaining
//  score1     out  4  player1 score, binary 0..WIN_SCORE
//  score2     out  4  player2 score, binary 0..WIN_SCORE
//  game_over  out  1  high while in OVER
//  winner     out  2  00 none, 01 p1, 10 p2, 11 draw; valid while game_over
// BEHAVIOUR
//  Clock and reset
//   - One clock: clk. rst is synchronous and active-high.
//   - Reset values: state=IDLE, stop=1, min=TIME_TENS, sec=TIME_ONES, score1=score2=0, game_over=0, winner=00.
//   - Reset also clears the prescaler and the serve counter.
//   - rst mid-operation aborts any state on the next edge.
//  Registered outputs
//   - All outputs are registered.
//   - stop changes on the edge that enters or leaves PLAY (1-cycle latency from cause).
//  IDLE
//   - stop=1.
//   - start -> SERVE: clears scores, reloads the timer, clears the prescaler, loads the serve counter.
//  SERVE
//   - stop=1. serve counter counts SERVE_CYCLES-1 down to 0; at 0 -> PLAY.
//   - miss1/miss2 and start are ignored. The timer is frozen.
//  PLAY
//   - stop=0. Prescaler counts 0..CLK_PER_SEC-1; on wrap, the timer decrements once.
//   - Timer decrement is BCD: sec 0 -> 9 with min-1; at 00 it holds 00.
//   - miss1 -> score2+1. miss2 -> score1+1. Then -> SERVE, with the serve counter reloaded.
//   - miss1 and miss2 are levels: only the first sampled cycle counts, because the controller leaves PLAY at once.
//   - miss1 and miss2 in the same cycle: only miss1 counts.
//   - Incremented score == WIN_SCORE -> OVER instead of SERVE.
//   - Timer reaches 00 (min=0 and sec=0 after decrement) -> OVER.
//   - Miss and timer expiry in the same cycle: the score updates first, then -> OVER.
//   - start is ignored.
//  OVER
//   - stop=1, game_over=1.
//   - winner is computed from the final scores: greater wins; equal gives 11.
//   - Outputs hold.
//   - start -> SERVE with a full clear, same as from IDLE.
//  Widths
//   - Prescaler and serve counter use $clog2 of their parameter.
//   - Scores saturate at WIN_SCORE. The prescaler is held at 0 outside PLAY.
// STRUCTURE
//  Shared package game_pkg
//   - State encoding: IDLE=2'd0, SERVE=2'd1, PLAY=2'd2, OVER=2'd3.
//   - Winner codes.
//   - Screen/paddle geometry constants shared with the ball state machine.
//  Sub-module bcd_countdown
//   - Ports: clk, rst, load, dec -> tens, ones, zero.
//   - Owns the two BCD digits and the borrow logic.
//  Top level
//   - Holds the FSM, prescaler, serve counter, scores and winner logic.
// TESTING  (override CLK_PER_SEC=4, SERVE_CYCLES=3, TIME_TENS=1, TIME_ONES=2, WIN_SCORE=3)
//  1 rst=1 for 2 cycles -> stop=1, min=1, sec=2, scores 0, game_over=0, winner=00.
//  2 start pulse -> SERVE; stop=1 for 3 cycles after entering SERVE, then stop=0; timer frozen while in SERVE.
//  3 PLAY 4 cycles -> sec 2->1; 8 more -> min=0, sec=9 (borrow); expiry at 00 -> game_over=1, winner=11.
//  4 miss1 held 3 cycles in PLAY -> score2=1 exactly once, stop=1 next cycle, re-serve after 3 cycles.
//  5 miss1+miss2 same cycle -> score2+1 only; third miss2 -> score1=3 -> OVER, winner=01, no SERVE.
//  6 rst mid-SERVE, and start in OVER -> full clear to IDLE / SERVE respectively; start ignored in PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the pong match controller and the ball state machine.
//   state_t        match sequencing states
//   WIN_*          winner codes driven on game_controller.winner
//   BCD_MAX        largest BCD digit, used by the countdown borrow
//   geometry       screen/paddle/ball sizes shared with the ball logic
//   winner_of()    final-score comparison
//   sat_inc()      saturating score increment
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int PADDLE_W  = 8;
  localparam int PADDLE_H  = 64;
  localparam int BALL_SIZE = 8;

  function automatic logic [1:0] winner_of(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2)      return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else              return WIN_DRAW;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] max);
    return (s >= max) ? max : s + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown (tens:ones) that stops at 00.
//   clk, rst   clock, synchronous active-high reset (loads the initial time)
//   load       reload the initial time
//   dec        count down one second; ignored at 00
//   tens, ones registered BCD digits
//   zero       high while the count is 00
module bcd_countdown
  import game_pkg::*;
#(
  parameter int TENS_INIT = 6,
  parameter int ONES_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero
);

  assign zero = (tens == 4'd0) && (ones == 4'd0);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      tens <= 4'(TENS_INIT);
      ones <= 4'(ONES_INIT);
    end else if (dec && !zero) begin
      if (ones == 4'd0) begin
        // borrow from the tens digit
        ones <= BCD_MAX;
        tens <= tens - 4'd1;
      end else begin
        ones <= ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Match-level controller downstream of the ball/paddle state machine.
// Sequences IDLE -> SERVE -> PLAY -> ... -> OVER, keeps scores and a BCD
// countdown, and feeds stop/min back to the ball logic.
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle start/restart request (honoured in IDLE/OVER)
//   miss1, miss2    player missed (levels from the ball state machine)
//   stop            hold ball/paddles at centre (registered)
//   min, sec        BCD tens/ones of seconds remaining
//   score1, score2  binary scores, saturating at WIN_SCORE
//   game_over       high while in OVER
//   winner          none/p1/p2/draw, valid while game_over
module game_controller
  import game_pkg::*;
#(
  parameter int CLK_PER_SEC  = 25_000_000,
  parameter int SERVE_CYCLES = 25_000_000,
  parameter int TIME_TENS    = 6,
  parameter int TIME_ONES    = 0,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miss1,
  input  logic       miss2,
  output logic       stop,
  output logic [3:0] min,
  output logic [3:0] sec,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int PW = (CLK_PER_SEC  > 1) ? $clog2(CLK_PER_SEC)  : 1;
  localparam int SW = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_PER_SEC - 1);
  localparam logic [SW-1:0] SERVE_LOAD = SW'(SERVE_CYCLES - 1);
  localparam logic [3:0]    WS         = 4'(WIN_SCORE);

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [SW-1:0] serve_cnt, serve_nxt;
  logic [3:0]    s1_nxt, s2_nxt;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic          tick, expiring;

  bcd_countdown #(
    .TENS_INIT (TIME_TENS),
    .ONES_INIT (TIME_ONES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .tens (min),
    .ones (sec),
    .zero (tmr_zero)
  );

  assign tick = (state == PLAY) && (presc == PRESC_MAX);
  // This tick lands the timer on 00 (or it is already parked there).
  assign expiring = tick && (tmr_zero || (min == 4'd0 && sec == 4'd1));

  always_comb begin
    state_nxt = state;
    presc_nxt = '0;
    serve_nxt = serve_cnt;
    s1_nxt    = score1;
    s2_nxt    = score2;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_nxt = SERVE;
          s1_nxt    = 4'd0;
          s2_nxt    = 4'd0;
          tmr_load  = 1'b1;
          serve_nxt = SERVE_LOAD;
        end
      end
      SERVE: begin
        if (serve_cnt == '0) state_nxt = PLAY;
        else                 serve_nxt = serve_cnt - 1'b1;
      end
      PLAY: begin
        tmr_dec   = tick;
        presc_nxt = tick ? '0 : presc + 1'b1;
        // miss1 has priority when both players miss in the same cycle
        if (miss1)      s2_nxt = sat_inc(score2, WS);
        else if (miss2) s1_nxt = sat_inc(score1, WS);
        if (miss1 || miss2) begin
          state_nxt = SERVE;
          serve_nxt = SERVE_LOAD;
        end
        // score is already updated above, so a simultaneous expiry still counts it
        if (((miss1 || miss2) && (s1_nxt == WS || s2_nxt == WS)) || expiring)
          state_nxt = OVER;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != PLAY) presc_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      serve_cnt <= '0;
      score1    <= 4'd0;
      score2    <= 4'd0;
      stop      <= 1'b1;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      serve_cnt <= serve_nxt;
      score1    <= s1_nxt;
      score2    <= s2_nxt;
      // outputs follow the next state so they change on the causing edge
      stop      <= (state_nxt != PLAY);
      game_over <= (state_nxt == OVER);
      winner    <= (state_nxt == OVER) ? winner_of(s1_nxt, s2_nxt) : WIN_NONE;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst, start, miss1, miss2;
  logic       stop, game_over;
  logic [3:0] min, sec, score1, score2;
  logic [1:0] winner;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       stp;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  game_controller #(
    .CLK_PER_SEC (4),
    .SERVE_CYCLES(3),
    .TIME_TENS   (1),
    .TIME_ONES   (2),
    .WIN_SCORE   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .miss1    (miss1),
    .miss2    (miss2),
    .stop     (stop),
    .min      (min),
    .sec      (sec),
    .score1   (score1),
    .score2   (score2),
    .game_over(game_over),
    .winner   (winner)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled on the falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_pop(input string name);
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if ({score1, score2, stop, game_over, winner} !== e) begin
        fails++;
        $display("FAIL %s: got s1=%0d s2=%0d stop=%0b go=%0b win=%b, want s1=%0d s2=%0d stop=%0b go=%0b win=%b",
                 name, score1, score2, stop, game_over, winner, e.s1, e.s2, e.stp, e.go, e.win);
      end
    end
  endtask

  task automatic wait_play(input string name);
    int n = 0;
    while (stop !== 1'b0 && n < 20) begin
      cyc(1);
      n++;
    end
    tests++;
    if (stop !== 1'b0) begin
      fails++;
      $display("FAIL %s: stop=%b after %0d cycles, want 0", name, stop, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    exp_q.push_back('{s1: 4'd0, s2: 4'd0, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(2);
    sb_pop("reset_outputs");
    tests++;
    if ({min, sec} !== 8'h12) begin
      fails++;
      $display("FAIL reset_timer: got %h want 12", {min, sec});
    end
    rst = 1'b0;
    cyc(3);
    tests++;
    if (stop !== 1'b1 || {min, sec} !== 8'h12) begin
      fails++;
      $display("FAIL idle_hold: got stop=%b time=%h want 1/12", stop, {min, sec});
    end
  endtask

  task automatic test_serve;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (stop !== 1'b1 || {min, sec} !== 8'h12) begin
        fails++;
        $display("FAIL serve_hold[%0d]: got stop=%b time=%h want 1/12", i, stop, {min, sec});
      end
      cyc(1);
    end
    tests++;
    if (stop !== 1'b0) begin
      fails++;
      $display("FAIL serve_release: got stop=%b want 0", stop);
    end
  endtask

  task automatic test_timer;
    cyc(4);
    tests++;
    if ({min, sec} !== 8'h11) begin
      fails++;
      $display("FAIL timer_first_sec: got %h want 11", {min, sec});
    end
    cyc(8);
    tests++;
    if ({min, sec} !== 8'h09) begin
      fails++;
      $display("FAIL timer_borrow: got %h want 09", {min, sec});
    end
    cyc(35);
    tests++;
    if ({min, sec} !== 8'h01 || game_over !== 1'b0) begin
      fails++;
      $display("FAIL timer_pre_expiry: got time=%h go=%b want 01/0", {min, sec}, game_over);
    end
    exp_q.push_back('{s1: 4'd0, s2: 4'd0, stp: 1'b1, go: 1'b1, win: 2'b11});
    cyc(1);
    sb_pop("timer_expiry");
    cyc(5);
    tests++;
    if ({min, sec} !== 8'h00 || game_over !== 1'b1 || winner !== 2'b11) begin
      fails++;
      $display("FAIL over_hold: got time=%h go=%b win=%b want 00/1/11", {min, sec}, game_over, winner);
    end
  endtask

  task automatic test_miss_held;
    start = 1'b1;
    exp_q.push_back('{s1: 4'd0, s2: 4'd0, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(1);
    start = 1'b0;
    sb_pop("restart_from_over");
    tests++;
    if ({min, sec} !== 8'h12) begin
      fails++;
      $display("FAIL restart_timer: got %h want 12", {min, sec});
    end
    wait_play("miss_held_play");
    miss1 = 1'b1;
    exp_q.push_back('{s1: 4'd0, s2: 4'd1, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(1);
    sb_pop("miss1_first");
    exp_q.push_back('{s1: 4'd0, s2: 4'd1, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(2);
    miss1 = 1'b0;
    sb_pop("miss1_held_once");
    cyc(1);
    tests++;
    if (stop !== 1'b0) begin
      fails++;
      $display("FAIL reserve_release: got stop=%b want 0", stop);
    end
  endtask

  task automatic test_double_miss;
    miss1 = 1'b1; miss2 = 1'b1;
    exp_q.push_back('{s1: 4'd0, s2: 4'd2, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(1);
    miss1 = 1'b0; miss2 = 1'b0;
    sb_pop("double_miss");
  endtask

  task automatic test_win;
    for (int i = 1; i <= 3; i++) begin
      wait_play("win_play");
      miss2 = 1'b1;
      exp_q.push_back('{s1: 4'(i), s2: 4'd2, stp: 1'b1, go: (i == 3), win: (i == 3) ? 2'b01 : 2'b00});
      cyc(1);
      miss2 = 1'b0;
      sb_pop("miss2_score");
    end
    exp_q.push_back('{s1: 4'd3, s2: 4'd2, stp: 1'b1, go: 1'b1, win: 2'b01});
    cyc(6);
    sb_pop("win_no_serve");
  endtask

  task automatic test_restart_rst;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    rst = 1'b1;
    exp_q.push_back('{s1: 4'd0, s2: 4'd0, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(1);
    rst = 1'b0;
    sb_pop("rst_mid_serve");
    exp_q.push_back('{s1: 4'd0, s2: 4'd0, stp: 1'b1, go: 1'b0, win: 2'b00});
    cyc(6);
    sb_pop("idle_after_rst");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    wait_play("play_after_rst");
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    tests++;
    if (stop !== 1'b0) begin
      fails++;
      $display("FAIL start_in_play: got stop=%b want 0", stop);
    end
    cyc(3);
    tests++;
    if ({min, sec} !== 8'h11) begin
      fails++;
      $display("FAIL play_after_start: got %h want 11", {min, sec});
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_timer();
    test_miss_held();
    test_double_miss();
    test_win();
    test_restart_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
